// File: rtl/systolic_sequencer.sv
// systolic_sequencer: loads A and B operands over a valid/ready stream, then
// clears, feeds (with diagonal skew) and drains a systolic_array before
// streaming its results row-major to a valid/yumi consumer.
// Optional build macro SEQ_PACE_EN: paces output offers to one per dwell_p cycles.
module systolic_sequencer #(
    parameter int width_p        = 8,
    parameter int array_width_p  = 2,
    parameter int array_height_p = 2,
    parameter int depth_p        = 2,
    parameter int pipe_p         = 1,
    parameter int dwell_p        = 60000000
) (
    input  logic                                     clk_i,
    input  logic                                     reset_i,
    input  logic                                     abort_i,
    input  logic                                     valid_i,
    input  logic [width_p-1:0]                       data_i,
    output logic                                     ready_o,
    output logic                                     sa_clear_o,
    output logic                                     sa_en_o,
    output logic [array_height_p*width_p-1:0]        row_data_o,
    output logic [array_width_p*width_p-1:0]         col_data_o,
    output logic [$clog2(array_height_p*array_width_p)-1:0] result_sel_o,
    input  logic [width_p-1:0]                       result_i,
    output logic                                     valid_o,
    output logic [width_p-1:0]                       data_o,
    input  logic                                     yumi_i,
    output logic                                     done_o
);

    localparam int H         = array_height_p;
    localparam int W         = array_width_p;
    localparam int K         = depth_p;
    localparam int A_WORDS   = H * K;
    localparam int N_WORDS   = H * K + K * W;
    localparam int MAX_HW    = (H > W) ? H : W;
    localparam int FEED_CYC  = K + MAX_HW - 1;
    localparam int DRAIN_CYC = H + W - 2 + pipe_p;
    localparam int RES       = H * W;
    localparam int T_MAX     = (FEED_CYC > DRAIN_CYC) ? FEED_CYC : DRAIN_CYC;
    localparam int CNT_W     = $clog2(N_WORDS);
    localparam int T_W       = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam int SEL_W     = $clog2(RES);

    typedef enum logic [2:0] {
        S_LOAD,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_OUT
    } state_t;

    state_t                    r_state;
    state_t                    w_state_n;
    logic [CNT_W-1:0]          r_cnt;
    logic [CNT_W-1:0]          w_cnt_n;
    logic [T_W-1:0]            r_t;
    logic [T_W-1:0]            w_t_n;
    logic [SEL_W-1:0]          r_sel;
    logic [SEL_W-1:0]          w_sel_n;
    logic [width_p-1:0]        r_buf [N_WORDS];
    logic                      r_clear;
    logic                      r_en;
    logic                      r_done;
    logic [H*width_p-1:0]      r_row;
    logic [H*width_p-1:0]      w_row_n;
    logic [W*width_p-1:0]      r_col;
    logic [W*width_p-1:0]      w_col_n;
    logic                      w_offer;
    logic                      w_accept;
    logic                      w_take;
    logic                      w_last_take;

`ifdef SEQ_PACE_EN
    localparam int DW_W = (dwell_p > 1) ? $clog2(dwell_p) : 1;
    logic [DW_W-1:0] r_dwell;

    // Dwell counter: runs only in OUT, restarts after every taken word.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_dwell <= '0;
        end else if (r_state != S_OUT || abort_i || w_take) begin
            r_dwell <= '0;
        end else if (r_dwell != DW_W'(dwell_p - 1)) begin
            r_dwell <= r_dwell + 1'b1;
        end
    end

    assign w_offer = (r_state == S_OUT) && (r_dwell == DW_W'(dwell_p - 1));
`else
    assign w_offer = (r_state == S_OUT);
`endif

    assign ready_o     = (r_state == S_LOAD);
    assign valid_o     = w_offer;
    assign data_o      = result_i;
    assign w_accept    = valid_i & ready_o;
    assign w_take      = yumi_i & w_offer;
    assign w_last_take = w_take && (r_sel == SEL_W'(RES - 1));

    assign sa_clear_o   = r_clear;
    assign sa_en_o      = r_en;
    assign row_data_o   = r_row;
    assign col_data_o   = r_col;
    assign result_sel_o = r_sel;
    assign done_o       = r_done;

    // Next-state and counter updates; abort overrides every transition.
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_t_n     = r_t;
        w_sel_n   = r_sel;
        case (r_state)
            S_LOAD: begin
                if (w_accept) begin
                    if (r_cnt == CNT_W'(N_WORDS - 1)) begin
                        w_state_n = S_CLEAR;
                        w_cnt_n   = '0;
                    end else begin
                        w_cnt_n = r_cnt + 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                w_state_n = S_FEED;
                w_t_n     = '0;
            end
            S_FEED: begin
                if (r_t == T_W'(FEED_CYC - 1)) begin
                    w_t_n     = '0;
                    w_state_n = (DRAIN_CYC == 0) ? S_OUT : S_DRAIN;
                end else begin
                    w_t_n = r_t + 1'b1;
                end
            end
            S_DRAIN: begin
                if (r_t == T_W'(DRAIN_CYC - 1)) begin
                    w_t_n     = '0;
                    w_state_n = S_OUT;
                end else begin
                    w_t_n = r_t + 1'b1;
                end
            end
            S_OUT: begin
                if (w_last_take) begin
                    w_sel_n   = '0;
                    w_state_n = S_LOAD;
                end else if (w_take) begin
                    w_sel_n = r_sel + 1'b1;
                end
            end
            default: w_state_n = S_LOAD;
        endcase
        if (abort_i) begin
            w_state_n = S_LOAD;
            w_cnt_n   = '0;
            w_t_n     = '0;
            w_sel_n   = '0;
        end
    end

    // Skewed operand selection for the upcoming cycle: row i carries A[i][t-i],
    // column j carries B[t-j][j], zero outside the valid diagonal band.
    always_comb begin
        w_row_n = '0;
        w_col_n = '0;
        if (w_state_n == S_FEED) begin
            for (int unsigned i = 0; i < H; i++) begin
                for (int unsigned k = 0; k < K; k++) begin
                    if (w_t_n == T_W'(i + k)) begin
                        w_row_n[i*width_p +: width_p] = r_buf[i*K + k];
                    end
                end
            end
            for (int unsigned j = 0; j < W; j++) begin
                for (int unsigned k = 0; k < K; k++) begin
                    if (w_t_n == T_W'(j + k)) begin
                        w_col_n[j*width_p +: width_p] = r_buf[A_WORDS + k*W + j];
                    end
                end
            end
        end
    end

    // State, counters and registered array controls (decoded from next state).
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= S_LOAD;
            r_cnt   <= '0;
            r_t     <= '0;
            r_sel   <= '0;
            r_clear <= 1'b0;
            r_en    <= 1'b0;
            r_row   <= '0;
            r_col   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_t     <= w_t_n;
            r_sel   <= w_sel_n;
            r_clear <= (w_state_n == S_CLEAR);
            r_en    <= (w_state_n == S_FEED) || (w_state_n == S_DRAIN);
            r_row   <= w_row_n;
            r_col   <= w_col_n;
            r_done  <= (r_state == S_OUT) && w_last_take && !abort_i;
        end
    end

    // Operand buffer write; contents need no reset.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_buf[r_cnt] <= data_i;
        end
    end

endmodule
